// File: rtl/sa_operand_skewer.sv
// Operand feeder for the systolic array: buffers K slices of A/B, then replays
// them as diagonally skewed, zero-padded wavefronts on the array row/column edges.
module sa_operand_skewer #(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [M*DATA_WIDTH-1:0] in_a_col,
    input  logic [N*DATA_WIDTH-1:0] in_b_row,
    output logic [M*DATA_WIDTH-1:0] out_a,
    output logic [N*DATA_WIDTH-1:0] out_b,
    output logic                    out_valid,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    done,
    output logic                    busy
);
    localparam int DW = DATA_WIDTH;
    localparam int T  = K + M + N - 2;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = $clog2(T + 1);

    typedef enum logic {S_LOAD, S_STREAM} state_t;

    state_t          r_state, w_state_nxt;
    logic [KW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [TW-1:0]   r_t, w_t_nxt;
    logic [M*DW-1:0] r_out_a, w_out_a_nxt, w_wave_a;
    logic [N*DW-1:0] r_out_b, w_out_b_nxt, w_wave_b;
    logic            r_valid, r_first, r_last, r_done;
    logic            w_valid_nxt, w_first_nxt, w_last_nxt, w_done_nxt;
    logic            w_accept, w_emit;
    logic [TW-1:0]   w_wave_t;

    logic [DW-1:0]   r_a_buf  [K][M];
    logic [DW-1:0]   r_b_buf  [K][N];
    logic [DW-1:0]   w_a_view [K][M];
    logic [DW-1:0]   w_b_view [K][N];

    assign in_ready  = (r_state == S_LOAD);
    assign busy      = (r_state != S_LOAD);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_valid = r_valid;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < M; i++) r_a_buf[r_beat_cnt][i] <= in_a_col[i*DW +: DW];
            for (int j = 0; j < N; j++) r_b_buf[r_beat_cnt][j] <= in_b_row[j*DW +: DW];
        end
    end

    // The slice being written this cycle is bypassed so the t=0 wavefront can
    // be registered on the same edge that accepts the last beat.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            for (int i = 0; i < M; i++)
                w_a_view[k][i] = (w_accept && (int'(r_beat_cnt) == k)) ? in_a_col[i*DW +: DW]
                                                                       : r_a_buf[k][i];
            for (int j = 0; j < N; j++)
                w_b_view[k][j] = (w_accept && (int'(r_beat_cnt) == k)) ? in_b_row[j*DW +: DW]
                                                                       : r_b_buf[k][j];
        end
    end

    always_comb begin
        w_wave_a = '0;
        w_wave_b = '0;
        for (int i = 0; i < M; i++)
            if ((int'(w_wave_t) >= i) && (int'(w_wave_t) - i < K))
                w_wave_a[i*DW +: DW] = w_a_view[KW'(int'(w_wave_t) - i)][i];
        for (int j = 0; j < N; j++)
            if ((int'(w_wave_t) >= j) && (int'(w_wave_t) - j < K))
                w_wave_b[j*DW +: DW] = w_b_view[KW'(int'(w_wave_t) - j)][j];
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_t_nxt        = r_t;
        w_wave_t       = '0;
        w_emit         = 1'b0;
        w_done_nxt     = 1'b0;
        if (flush) begin
            w_state_nxt    = S_LOAD;
            w_beat_cnt_nxt = '0;
            w_t_nxt        = '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        if (r_beat_cnt == KW'(K - 1)) begin
                            w_state_nxt    = S_STREAM;
                            w_beat_cnt_nxt = '0;
                            w_t_nxt        = '0;
                            w_emit         = 1'b1;
                        end else begin
                            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (r_t == TW'(T - 1)) begin
                        w_state_nxt = S_LOAD;
                        w_t_nxt     = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_t_nxt  = r_t + 1'b1;
                        w_wave_t = r_t + 1'b1;
                        w_emit   = 1'b1;
                    end
                end
                default: w_state_nxt = S_LOAD;
            endcase
        end
        w_valid_nxt = w_emit;
        w_first_nxt = w_emit && (w_wave_t == '0);
        w_last_nxt  = w_emit && (w_wave_t == TW'(T - 1));
        w_out_a_nxt = w_emit ? w_wave_a : '0;
        w_out_b_nxt = w_emit ? w_wave_b : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_LOAD;
            r_beat_cnt <= '0;
            r_t        <= '0;
            r_out_a    <= '0;
            r_out_b    <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_t        <= w_t_nxt;
            r_out_a    <= w_out_a_nxt;
            r_out_b    <= w_out_b_nxt;
            r_valid    <= w_valid_nxt;
            r_first    <= w_first_nxt;
            r_last     <= w_last_nxt;
            r_done     <= w_done_nxt;
        end
    end
endmodule

// File: tb/tb_sa_operand_skewer.sv
// Scoreboard bench for sa_operand_skewer: the driver pushes expected wavefronts
// (tagged with their cycle) from a matrix model; a negedge monitor pops and compares.
module tb_sa_operand_skewer;
    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int T  = K + M + N - 2;
    localparam int AW = M * DW;
    localparam int BW = N * DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a_col = '0;
    logic [BW-1:0] in_b_row = '0;
    logic [AW-1:0] out_a;
    logic [BW-1:0] out_b;
    logic          out_valid, out_first, out_last, done, busy;

    sa_operand_skewer #(.M(M), .K(K), .N(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a_col(in_a_col), .in_b_row(in_b_row),
        .out_a(out_a), .out_b(out_b),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic          first;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DW-1:0] ma [M][K];
    logic [DW-1:0] mb [K][N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected wavefront for cycle t straight from the matrix definition.
    task automatic push_stream(input int p);
        exp_t e;
        for (int t = 0; t < T; t++) begin
            e.a = '0;
            e.b = '0;
            for (int i = 0; i < M; i++)
                if (t - i >= 0 && t - i < K) e.a[i*DW +: DW] = ma[i][t-i];
            for (int j = 0; j < N; j++)
                if (t - j >= 0 && t - j < K) e.b[j*DW +: DW] = mb[t-j][j];
            e.first = (t == 0);
            e.last  = (t == T - 1);
            e.cyc   = p + 1 + t;
            exp_q.push_back(e);
        end
        done_q.push_back(p + 1 + T);
    endtask

    // gap_mode: 0 back-to-back, 1 alternating idle cycles, 2 random idle cycles
    task automatic load_tile(input int gap_mode);
        int  k = 0;
        int  c = 0;
        bit  idle;
        while (k < K) begin
            idle = (gap_mode == 1) ? (c % 2 == 1) :
                   (gap_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (idle) begin
                in_valid = 1'b0;
                in_a_col = AW'($urandom);
                in_b_row = BW'($urandom);
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < M; i++) in_a_col[i*DW +: DW] = ma[i][k];
                for (int j = 0; j < N; j++) in_b_row[j*DW +: DW] = mb[k][j];
                chk("in_ready_load", in_ready, 1'b1);
                if (k == K - 1) push_stream(cyc);
                k++;
            end
            tick();
            c++;
        end
        in_valid = 1'b0;
    endtask

    // Offers junk beats while streaming; none may be taken.
    task automatic run_stream(input int ncyc);
        for (int s = 0; s < ncyc; s++) begin
            chk("in_ready_stream", in_ready, 1'b0);
            chk("busy_stream", busy, 1'b1);
            in_valid = 1'($urandom_range(0, 1));
            in_a_col = AW'($urandom);
            in_b_row = BW'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = DW'(10 * i + k);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = DW'(10 * k + j);
    endtask

    task automatic fill_random();
        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = DW'($urandom);
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = DW'($urandom);
    endtask

    always @(negedge clk) begin
        exp_t it;
        bit   exp_done;
        if (reset_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1'b1, 1'b0);
                end else begin
                    it = exp_q.pop_front();
                    chk("wave_cycle", 64'(cyc), 64'(it.cyc));
                    chk("out_a", out_a, it.a);
                    chk("out_b", out_b, it.b);
                    chk("out_first", out_first, it.first);
                    chk("out_last", out_last, it.last);
                end
            end else begin
                chk("idle_out_a", out_a, '0);
                chk("idle_out_b", out_b, '0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    it = exp_q.pop_front();
                    chk("missing_wave", 64'(cyc), 64'(it.cyc));
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
            exp_done = (done_q.size() > 0 && done_q[0] == cyc);
            if (exp_done) void'(done_q.pop_front());
            chk("done", done, exp_done);
        end
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_a", out_a, '0);
        chk("rst_out_b", out_b, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        fill_pattern();
        load_tile(0);
        run_stream(T);

        fill_random();
        load_tile(1);
        run_stream(T);

        for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) ma[i][k] = 8'h80;
        for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mb[k][j] = 8'h7F;
        load_tile(0);
        run_stream(T);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            load_tile(2);
            run_stream(T);
            repeat ($urandom_range(0, 2)) tick();
        end

        fill_pattern();
        load_tile(0);
        run_stream(4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a_col = AW'($urandom);
        in_b_row = BW'($urandom);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        done_q.delete();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_a", out_a, '0);
        chk("flush_b", out_b, '0);
        chk("flush_done", done, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        tick();
        fill_random();
        load_tile(0);
        run_stream(T);

        fill_random();
        load_tile(0);
        run_stream(2);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        done_q.delete();
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_a", out_a, '0);
        chk("arst_b", out_b, '0);
        chk("arst_first", out_first, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        tick();

        fill_random();
        load_tile(0);
        run_stream(T);
        chk("b2b_done_cycle_ready", in_ready, 1'b1);
        fill_pattern();
        load_tile(0);
        run_stream(T);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sa_operand_skewer.md
Name: sa_operand_skewer

Overview:
- Feeder stage directly upstream of the systolic array.
- Accepts one K-slice per beat: column k of A (M elements) plus row k of B (N elements). Buffers all K slices.
- Replays the buffered slices as diagonally skewed, zero-padded operand wavefronts on the array's row (A) and column (B) edges.
- Flags the first and last wavefront cycles and pulses done once every PE has received its final operand.

Parameters:
- M, 4, rows of A / rows of the array
- K, 4, shared inner dimension (beats per tile)
- N, 4, columns of B / columns of the array
- DATA_WIDTH, 8, signed operand width

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns block to LOAD and discards buffer
- in_valid  input  1  load beat valid
- in_ready  output  1  block can accept a load beat
- in_a_col  input  M*DATA_WIDTH  A[i][k] in bits [i*DW +: DW], signed
- in_b_row  input  N*DATA_WIDTH  B[k][j] in bits [j*DW +: DW], signed
- out_a  output  M*DATA_WIDTH  row-edge operand for array row i, slot i
- out_b  output  N*DATA_WIDTH  column-edge operand for array column j, slot j
- out_valid  output  1  wavefront cycle in progress
- out_first  output  1  first wavefront cycle (array clears accumulators)
- out_last  output  1  final wavefront cycle
- done  output  1  one-cycle pulse after out_last
- busy  output  1  state != LOAD

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=LOAD, beat counter=0, stream counter=0
  - out_a=0, out_b=0, out_valid=0, out_first=0, out_last=0, done=0, busy=0
  - Buffer contents are don't-care.
- States: LOAD and STREAM.
- LOAD:
  - in_ready=1 (combinational from state).
  - Each accepted beat (in_valid & in_ready) writes slice k = beat counter, then increments the counter.
  - Acceptance of beat K-1 moves the block to STREAM on the next edge. The beat counter resets to 0; the stream counter resets to 0.
- STREAM:
  - in_ready=0; in_valid is ignored.
  - Stream length T = K+M+N-2 cycles, counter t = 0..T-1.
  - All outputs are registered. The first wavefront appears the cycle after beat K-1 is accepted.
- Wavefront cycle t:
  - out_a slot i = A[i][t-i] if 0 <= t-i < K, else 0.
  - out_b slot j = B[t-j][j] if 0 <= t-j < K, else 0.
  - Zero padding is exact, so trailing cycles carry only zeros while the skew propagates to PE(M-1,N-1).
- Flags:
  - out_valid=1 for all T cycles.
  - out_first=1 only at t=0.
  - out_last=1 only at t=T-1 (both set if T=1).
- Completion:
  - After t=T-1, state returns to LOAD and the output data registers return to 0.
  - done=1 for exactly one cycle, coincident with the first LOAD cycle.
  - A new beat may be accepted in that same cycle.
- flush:
  - Highest priority below reset.
  - Next edge: state=LOAD, counters=0, out_valid/out_first/out_last=0, outputs=0, done=0.
  - A beat presented in the flush cycle is dropped.
- Reset asserted mid-LOAD or mid-STREAM takes effect immediately (async); no done is produced.
- Widths:
  - Counters sized clog2(K) and clog2(T+1); beat counter does not wrap past K-1.
  - Operands pass through unmodified; no sign extension inside this block.

Test Plan:
- M=K=N=4; load A[i][k]=10i+k, B[k][j]=10k+j.
  - Require stream t=0..9 with first/last at t=0 and t=9, and done at the next cycle.
  - t=0: out_a={0,0,0,A00=0} (slot0=0), out_b slot0=B00=0.
  - t=3: out_a slots {A03,A12,A21,A30}={3,12,21,30}, out_b slots {B30,B21,B12,B03}={30,21,12,3}.
  - t=9: all zeros.
- Backpressure/gaps: in_valid toggled 1,0,1,0,... -> exactly 4 beats stored in order, in_ready=0 through STREAM, and beats offered during STREAM are not written (stream data unchanged).
- Signed extremes: A=-128 everywhere, B=127 everywhere -> out slots carry 0x80/0x7F bit-exact, zeros outside the diagonal band.
- flush asserted at t=4 -> next cycle out_valid=0, outputs 0, no done, in_ready=1. A fresh 4-beat load streams correctly.
- reset_n pulsed low mid-STREAM (t=2, between edges) -> outputs 0 immediately without a clock edge. After release, busy=0 and in_ready=1.
- Back-to-back tiles: next tile's first beat presented in the done cycle is accepted, and the second stream's t=0 follows exactly K cycles after the done cycle.
